mode_led_driver: RTL and testbench
==================================

// Module: mode_led_driver
// PURPOSE
//   Presents the active operating mode back to the user. Consumes the one-hot mode flags
//   produced by the key/mode FSM and drives the board LEDs (active-low):
//   - led_o[2:0] give a static mode indication.
//   - led_o[3] plays a blink code whenever the mode changes.
//   Sits between the mode FSM and the LED pins.
// PARAMETERS
//   TICK_DIV   20'd1_000_000  clock cycles per blink tick (>=2)
//   ON_TICKS   8'd10          ticks led_o[3] is lit per blink (>=1)
//   OFF_TICKS  8'd10          ticks led_o[3] is dark after each blink (>=1)
// PORTS
//   sys_clk_i         in   1  system clock
//   sys_rst_i         in   1  synchronous reset, active-high
//   is_count_mode_i   in   1  count mode active
//   is_color_mode_i   in   1  color mode active
//   is_detect_mode_i  in   1  detect mode active
//   led_o             out  4  LEDs, active-low (0 = lit)
//   blink_busy_o      out  1  high while a blink code is playing
//   mode_err_o        out  1  high while more than one mode flag is asserted
// BEHAVIOUR
//   Reset (sys_rst_i high at a clock edge)
//   - led_o=4'b1111, blink_busy_o=0, mode_err_o=0.
//   - mode_q=WAIT, state=IDLE, prescaler=0, counters=0.
//   - Reset wins over every other event, including mid-blink.
//   Mode decode (combinational from the inputs)
//   - No flag set: WAIT, code 4.
//   - count only: code 1. color only: code 2. detect only: code 3.
//   - More than one flag set: ERR.
//   Change detect
//   - At each edge, if the decoded mode != mode_q: mode_q <= decoded mode.
//   - If the new mode is not ERR: state<=ON, prescaler<=0, tick_cnt<=0, blink_cnt<=code.
//     This applies even mid-blink: the sequence restarts with the new code.
//   - If the new mode is ERR: state<=IDLE.
//   Prescaler
//   - Counts 0..TICK_DIV-1 and wraps. tick = (prescaler==TICK_DIV-1).
//   - Runs only in ON and OFF; held at 0 in IDLE.
//   FSM states: IDLE, ON, OFF
//   - IDLE: hold until a mode change.
//   - ON: on a tick, tick_cnt++. When tick_cnt reaches ON_TICKS-1 on a tick:
//     state<=OFF, tick_cnt<=0.
//   - OFF: on a tick, tick_cnt++. When tick_cnt reaches OFF_TICKS-1 on a tick:
//     blink_cnt--, tick_cnt<=0.
//     Then state<=ON if blink_cnt!=1, else state<=IDLE.
//   Outputs (registered from state/mode_q; visible 2 edges after an input change)
//   - led_o[3] = 0 in ON, 1 otherwise.
//   - led_o[2:0]: WAIT 3'b111, count 3'b110, color 3'b101, detect 3'b011, ERR 3'b000.
//   - blink_busy_o = (state!=IDLE).
//   - mode_err_o = (mode_q==ERR).
//   Timing and widths
//   - One blink lasts (ON_TICKS+OFF_TICKS)*TICK_DIV cycles.
//   - A code N keeps blink_busy_o high for N*(ON_TICKS+OFF_TICKS)*TICK_DIV cycles.
//   - prescaler width 20 bits; tick_cnt 8 bits; blink_cnt 3 bits.
//   Boundary cases
//   - Mode change on the same edge as the final OFF tick: the change wins (restart).
//   - Return to the same mode before its sequence ends: no change is seen, so the
//     sequence continues.
// TESTING (TICK_DIV=4, ON_TICKS=2, OFF_TICKS=2 -> 16 cycles per blink)
//   1. Reset, flags 0 for 50 cycles -> led_o=4'b1111, blink_busy_o=0 throughout.
//   2. Set count at cycle 10 -> led_o=4'b0110 from cycle 12 for 8 cycles, then 4'b1110;
//      blink_busy_o low after 16 cycles.
//   3. Set color only -> two 8-cycle low pulses on led_o[3]; led_o[2:0]=3'b101;
//      busy for 32 cycles.
//   4. Detect mid-way through the 2nd color blink -> sequence restarts;
//      exactly 3 pulses follow; led_o[2:0]=3'b011.
//   5. Set count+color together -> led_o=4'b1000, mode_err_o=1, blink_busy_o=0;
//      clear color -> 1 blink, mode_err_o=0.
//   6. Assert sys_rst_i during an ON phase -> next edge: led_o=4'b1111, blink_busy_o=0,
//      state IDLE.

Source files
------------

// File: rtl/mode_led_driver.sv
// mode_led_driver: turns the one-hot mode flags from the mode FSM into LED
// indications. led_o[2:0] show the active mode statically, and led_o[3] plays
// a blink code (N blinks for mode code N) each time the mode changes.
// All LEDs are active-low.
module mode_led_driver #(
  parameter logic [19:0] TICK_DIV  = 20'd1_000_000,
  parameter logic [7:0]  ON_TICKS  = 8'd10,
  parameter logic [7:0]  OFF_TICKS = 8'd10
) (
  input  logic       sys_clk_i,
  input  logic       sys_rst_i,
  input  logic       is_count_mode_i,
  input  logic       is_color_mode_i,
  input  logic       is_detect_mode_i,
  output logic [3:0] led_o,
  output logic       blink_busy_o,
  output logic       mode_err_o
);

  // Blink sequencer states.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ON   = 2'd1;
  localparam logic [1:0] ST_OFF  = 2'd2;

  // Mode values double as the blink code; ERR has no code and never blinks.
  localparam logic [2:0] MODE_ERR    = 3'd0;
  localparam logic [2:0] MODE_COUNT  = 3'd1;
  localparam logic [2:0] MODE_COLOR  = 3'd2;
  localparam logic [2:0] MODE_DETECT = 3'd3;
  localparam logic [2:0] MODE_WAIT   = 3'd4;

  localparam logic [19:0] TICK_LAST = TICK_DIV - 20'd1;
  localparam logic [7:0]  ON_LAST   = ON_TICKS - 8'd1;
  localparam logic [7:0]  OFF_LAST  = OFF_TICKS - 8'd1;

  // Collapse the flag set into one mode; any overlap is an error.
  function automatic logic [2:0] decode_mode(input logic count_f,
                                             input logic color_f,
                                             input logic detect_f);
    logic [2:0] mode;
    case ({detect_f, color_f, count_f})
      3'b000:  mode = MODE_WAIT;
      3'b001:  mode = MODE_COUNT;
      3'b010:  mode = MODE_COLOR;
      3'b100:  mode = MODE_DETECT;
      default: mode = MODE_ERR;
    endcase
    return mode;
  endfunction

  // Static active-low pattern for led_o[2:0]; ERR lights all three.
  function automatic logic [2:0] mode_pattern(input logic [2:0] mode);
    logic [2:0] pat;
    case (mode)
      MODE_WAIT:   pat = 3'b111;
      MODE_COUNT:  pat = 3'b110;
      MODE_COLOR:  pat = 3'b101;
      MODE_DETECT: pat = 3'b011;
      default:     pat = 3'b000;
    endcase
    return pat;
  endfunction

  logic [2:0]  mode_d;
  logic [2:0]  mode_q;
  logic [1:0]  state;
  logic [19:0] prescaler;
  logic [7:0]  tick_cnt;
  logic [2:0]  blink_cnt;
  logic        tick;
  logic        mode_change;

  // ---- stage p0: decode and sequencer ----
  assign mode_d      = decode_mode(is_count_mode_i, is_color_mode_i, is_detect_mode_i);
  assign mode_change = (mode_d != mode_q);
  assign tick        = (prescaler == TICK_LAST);

  // Mode tracking and blink sequencer; a mode change overrides any tick activity.
  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      mode_q    <= MODE_WAIT;
      state     <= ST_IDLE;
      prescaler <= '0;
      tick_cnt  <= '0;
      blink_cnt <= '0;
    end else if (mode_change) begin
      mode_q <= mode_d;
      if (mode_d != MODE_ERR) begin
        // Restart from the first blink, even if a code is already playing.
        state     <= ST_ON;
        prescaler <= '0;
        tick_cnt  <= '0;
        blink_cnt <= mode_d;
      end else begin
        state     <= ST_IDLE;
        prescaler <= '0;
      end
    end else begin
      case (state)
        ST_ON: begin
          prescaler <= tick ? 20'd0 : prescaler + 20'd1;
          if (tick) begin
            if (tick_cnt == ON_LAST) begin
              state    <= ST_OFF;
              tick_cnt <= '0;
            end else begin
              tick_cnt <= tick_cnt + 8'd1;
            end
          end
        end
        ST_OFF: begin
          prescaler <= tick ? 20'd0 : prescaler + 20'd1;
          if (tick) begin
            if (tick_cnt == OFF_LAST) begin
              tick_cnt  <= '0;
              blink_cnt <= blink_cnt - 3'd1;
              // blink_cnt==1 means the blink just finished was the last one.
              state     <= (blink_cnt != 3'd1) ? ST_ON : ST_IDLE;
            end else begin
              tick_cnt <= tick_cnt + 8'd1;
            end
          end
        end
        default: begin
          state     <= ST_IDLE;
          prescaler <= '0;
        end
      endcase
    end
  end

  // ---- stage p1: registered LED outputs ----
  logic [3:0] led_p1;
  logic       busy_p1;
  logic       err_p1;

  // Register the pin-facing outputs from the current sequencer state and mode.
  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      led_p1  <= 4'b1111;
      busy_p1 <= 1'b0;
      err_p1  <= 1'b0;
    end else begin
      led_p1  <= {(state != ST_ON), mode_pattern(mode_q)};
      busy_p1 <= (state != ST_IDLE);
      err_p1  <= (mode_q == MODE_ERR);
    end
  end

  assign led_o        = led_p1;
  assign blink_busy_o = busy_p1;
  assign mode_err_o   = err_p1;

endmodule

// File: tb/tb_mode_led_driver.sv
// Self-checking bench for mode_led_driver with a short tick (16 cycles per blink).
// A timeline model predicts every output on every cycle: it remembers when the
// current blink code started and derives ON/OFF/idle from the elapsed cycles.
module tb_mode_led_driver;

  localparam int TD   = 4;
  localparam int ONT  = 2;
  localparam int OFFT = 2;
  localparam int P    = (ONT + OFFT) * TD;

  logic       clk = 1'b0;
  logic       rst;
  logic       f_count, f_color, f_detect;
  logic [3:0] led;
  logic       busy, err;

  always #5 clk = ~clk;

  mode_led_driver #(
    .TICK_DIV (20'(TD)),
    .ON_TICKS (8'(ONT)),
    .OFF_TICKS(8'(OFFT))
  ) dut (
    .sys_clk_i       (clk),
    .sys_rst_i       (rst),
    .is_count_mode_i (f_count),
    .is_color_mode_i (f_color),
    .is_detect_mode_i(f_detect),
    .led_o           (led),
    .blink_busy_o    (busy),
    .mode_err_o      (err)
  );

  int errors = 0;
  int checks = 0;

  // Model: mode value 0 = ERR, 1..3 = count/color/detect, 4 = WAIT.
  int      m_mode;
  longint  m_cyc   = 0;
  longint  m_start = 0;
  int      m_code  = 0;
  bit      m_active = 0;
  logic [3:0] pend_led = 4'b1111, exp_led;
  logic       pend_busy = 0, exp_busy, pend_err = 0, exp_err;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at t=%0t", name, act, act, req, req, $time);
    end
  endtask

  function automatic int decode(input logic c, input logic co, input logic d);
    int n;
    n = int'(c) + int'(co) + int'(d);
    if (n > 1) return 0;
    if (n == 0) return 4;
    if (c) return 1;
    if (co) return 2;
    return 3;
  endfunction

  function automatic logic [2:0] pat(input int m);
    case (m)
      4: return 3'b111;
      1: return 3'b110;
      2: return 3'b101;
      3: return 3'b011;
      default: return 3'b000;
    endcase
  endfunction

  // Advance the model by one clock edge and predict what the state looks like after it.
  task automatic model_edge();
    int  dm;
    bit  on, bz;
    longint e;
    m_cyc++;
    if (rst) begin
      m_mode   = 4;
      m_active = 0;
    end else begin
      dm = decode(f_count, f_color, f_detect);
      if (dm != m_mode) begin
        m_mode = dm;
        if (dm != 0) begin
          m_active = 1;
          m_start  = m_cyc;
          m_code   = dm;
        end else begin
          m_active = 0;
        end
      end
    end
    on = 0;
    bz = 0;
    if (m_active) begin
      e = m_cyc - m_start;
      if (e < longint'(m_code) * P) begin
        bz = 1;
        on = (e % P) < (ONT * TD);
      end else begin
        m_active = 0;
      end
    end
    pend_led  = {~on, pat(m_mode)};
    pend_busy = bz;
    pend_err  = (m_mode == 0);
  endtask

  // One clock: outputs after this edge reflect the model state after the previous edge.
  task automatic step();
    @(posedge clk);
    if (rst) begin
      exp_led = 4'b1111; exp_busy = 0; exp_err = 0;
    end else begin
      exp_led = pend_led; exp_busy = pend_busy; exp_err = pend_err;
    end
    model_edge();
    #1;
    check("model_led", int'(led), int'(exp_led));
    check("model_busy", int'(busy), int'(exp_busy));
    check("model_err", int'(err), int'(exp_err));
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic set_flags(input logic [2:0] f);
    {f_detect, f_color, f_count} = f;
  endtask

  typedef struct {
    logic [2:0] flags;   // {detect, color, count}
    int         hold;
    logic [3:0] x_led;
    logic       x_busy;
    logic       x_err;
  } vec_t;

  vec_t vecs[12];
  int   lows, falls, busy_cycles;
  logic prev3;

  initial begin
    m_mode = 4;
    rst = 1'b1;
    set_flags(3'b000);
    vecs[0]  = '{3'b000, 10, 4'b1111, 1'b0, 1'b0};
    vecs[1]  = '{3'b001,  2, 4'b0110, 1'b1, 1'b0};
    vecs[2]  = '{3'b001, 16, 4'b1110, 1'b0, 1'b0};
    vecs[3]  = '{3'b011,  2, 4'b1000, 1'b0, 1'b1};
    vecs[4]  = '{3'b001,  2, 4'b0110, 1'b1, 1'b0};
    vecs[5]  = '{3'b010,  2, 4'b0101, 1'b1, 1'b0};
    vecs[6]  = '{3'b010, 10, 4'b1101, 1'b1, 1'b0};
    vecs[7]  = '{3'b100, 40, 4'b0011, 1'b1, 1'b0};
    vecs[8]  = '{3'b100, 20, 4'b1011, 1'b0, 1'b0};
    vecs[9]  = '{3'b000,  2, 4'b0111, 1'b1, 1'b0};
    vecs[10] = '{3'b111,  2, 4'b1000, 1'b0, 1'b1};
    vecs[11] = '{3'b110,  2, 4'b1000, 1'b0, 1'b1};

    steps(3);
    rst = 1'b0;

    // Idle with no flags: nothing lit, never busy.
    steps(50);
    check("idle_led", int'(led), 4'hF);
    check("idle_busy", int'(busy), 0);

    // Table of mode patterns with hand-derived expectations.
    foreach (vecs[i]) begin
      set_flags(vecs[i].flags);
      steps(vecs[i].hold);
      check($sformatf("vec%0d_led", i), int'(led), int'(vecs[i].x_led));
      check($sformatf("vec%0d_busy", i), int'(busy), int'(vecs[i].x_busy));
      check($sformatf("vec%0d_err", i), int'(err), int'(vecs[i].x_err));
    end

    // Count from idle: one 8-cycle pulse, 16 busy cycles.
    set_flags(3'b000);
    steps(80);
    set_flags(3'b001);
    lows = 0; busy_cycles = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (!led[3]) lows++;
      if (busy) busy_cycles++;
    end
    check("count_low_cycles", lows, ONT * TD);
    check("count_busy_cycles", busy_cycles, P);
    check("count_led_final", int'(led), 4'b1110);

    // Color, then detect during the OFF half of the second color blink.
    set_flags(3'b010);
    steps(27);
    check("color_2nd_off", int'(led), 4'b1101);
    set_flags(3'b100);
    falls = 0; lows = 0; prev3 = led[3];
    for (int i = 0; i < 60; i++) begin
      step();
      if (prev3 && !led[3]) falls++;
      if (!led[3]) lows++;
      prev3 = led[3];
    end
    check("detect_pulses", falls, 3);
    check("detect_low_cycles", lows, 3 * ONT * TD);
    check("detect_done_led", int'(led), 4'b1011);
    check("detect_done_busy", int'(busy), 0);

    // Mode change on the same edge as the final OFF tick restarts the code.
    set_flags(3'b001);
    steps(16);
    set_flags(3'b010);
    steps(2);
    check("final_tick_led", int'(led), 4'b0101);
    check("final_tick_busy", int'(busy), 1);

    // A flag glitch that is gone before the edge is never seen.
    steps(10);
    set_flags(3'b100);
    #2;
    set_flags(3'b010);
    steps(8);
    check("glitch_led", int'(led), 4'b0101);

    // Reset during an ON phase wins immediately.
    set_flags(3'b001);
    steps(3);
    rst = 1'b1;
    step();
    check("rst_led", int'(led), 4'hF);
    check("rst_busy", int'(busy), 0);
    check("rst_err", int'(err), 0);
    rst = 1'b0;
    steps(3);
    check("post_rst_led", int'(led), 4'b0110);

    // Random flag sequences with occasional reset, all checked by the model.
    for (int n = 0; n < 120; n++) begin
      logic [2:0] f;
      int r;
      r = $urandom_range(0, 9);
      if (r < 6) f = 3'b001 << $urandom_range(0, 2);
      else if (r < 8) f = 3'($urandom_range(0, 7));
      else f = 3'b000;
      set_flags(f);
      if ($urandom_range(0, 49) == 0) begin
        rst = 1'b1;
        step();
        rst = 1'b0;
      end
      steps($urandom_range(1, 40));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
